// File: rtl/multicycle_controller.sv
// Multicycle RV32I-style control unit: sequences fetch/decode/execute phases,
// drives datapath selects and strobes, and counts retired instructions.
module multicycle_controller #(
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int SUPPORT_JALR    = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             BrEq,
    input  logic             BrLT,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ImmSrc,
    output logic [3:0]       ALUControl,
    output logic             BrUn,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRPC,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    state_t           state_q, state_d, state_cur;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic [3:0]       alu_dec;
    logic             taken;

    // Outputs follow FETCH while reset is high, not only after the edge.
    assign state_cur = reset ? S_FETCH : state_q;

    // Immediate format selected from the opcode alone
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_LOAD, OP_JALR, OP_I: ImmSrc = 3'b000;
            OP_STORE:               ImmSrc = 3'b001;
            OP_BRANCH:              ImmSrc = 3'b010;
            OP_JAL:                 ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:       ImmSrc = 3'b100;
            default:                ImmSrc = 3'b000;
        endcase
    end

    // ALU operation for R/I-type execute phases
    always_comb begin
        alu_dec = 4'b0000;
        case (funct3)
            3'b000: alu_dec = (op == OP_R && funct7b5) ? 4'b0001 : 4'b0000;
            3'b001: alu_dec = 4'b0111;
            3'b010: alu_dec = 4'b0101;
            3'b011: alu_dec = 4'b0110;
            3'b100: alu_dec = 4'b0100;
            3'b101: alu_dec = funct7b5 ? 4'b1001 : 4'b1000;
            3'b110: alu_dec = 4'b0011;
            3'b111: alu_dec = 4'b0010;
            default: alu_dec = 4'b0000;
        endcase
    end

    // Branch outcome from the datapath comparator flags
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:         taken = BrEq;
            3'b001:         taken = ~BrEq;
            3'b100, 3'b110: taken = BrLT;
            3'b101, 3'b111: taken = ~BrLT;
            default:        taken = 1'b0;
        endcase
    end

    // Next-state, control outputs and retire pulse
    always_comb begin
        state_d       = state_cur;
        retire        = 1'b0;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = 4'b0000;
        BrUn          = 1'b0;
        illegal_instr = 1'b0;
        case (state_cur)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECUTER;
                    OP_I:              state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    OP_BRANCH: begin
                        if (funct3 == 3'b010 || funct3 == 3'b011)
                            state_d = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
                        else
                            state_d = S_BRANCH;
                    end
                    OP_JALR: begin
                        if (SUPPORT_JALR != 0)
                            state_d = S_JALR;
                        else
                            state_d = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
                    end
                    default: state_d = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = alu_dec;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                BrUn    = funct3[1];
                PCWrite = taken;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
                state_d   = S_JALRPC;
            end
            S_JALRPC: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_LUI: begin
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                state_d       = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign instret_d = instret_q + CNT_W'(retire);
    assign instret   = instret_q;

    // State and retired-instruction counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: two controller instances (default build and
// a no-trap / no-JALR / 4-bit counter build) checked cycle by cycle against an
// instruction-level reference model.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst1, rst2;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, BrEq, BrLT, mem_ready;

    logic       PCWrite1, AdrSrc1, MemWrite1, IRWrite1, RegWrite1, BrUn1, ill1;
    logic [1:0] ResultSrc1, ALUSrcA1, ALUSrcB1;
    logic [2:0] ImmSrc1;
    logic [3:0] ALUControl1;
    logic [31:0] instret1;

    logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, BrUn2, ill2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2;
    logic [2:0] ImmSrc2;
    logic [3:0] ALUControl2;
    logic [3:0] instret2;

    logic [19:0] obs1, obs2;
    bit          sel;
    logic [31:0] exp_cnt;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_controller dut1 (
        .clk(clk), .reset(rst1), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .BrEq(BrEq), .BrLT(BrLT), .mem_ready(mem_ready),
        .PCWrite(PCWrite1), .AdrSrc(AdrSrc1), .MemWrite(MemWrite1), .IRWrite(IRWrite1),
        .RegWrite(RegWrite1), .ResultSrc(ResultSrc1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
        .ImmSrc(ImmSrc1), .ALUControl(ALUControl1), .BrUn(BrUn1), .illegal_instr(ill1),
        .instret(instret1)
    );

    multicycle_controller #(.TRAP_ON_ILLEGAL(0), .SUPPORT_JALR(0), .CNT_W(4)) dut2 (
        .clk(clk), .reset(rst2), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .BrEq(BrEq), .BrLT(BrLT), .mem_ready(mem_ready),
        .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
        .RegWrite(RegWrite2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
        .ImmSrc(ImmSrc2), .ALUControl(ALUControl2), .BrUn(BrUn2), .illegal_instr(ill2),
        .instret(instret2)
    );

    assign obs1 = {PCWrite1, AdrSrc1, MemWrite1, IRWrite1, RegWrite1, ResultSrc1,
                   ALUSrcA1, ALUSrcB1, ImmSrc1, ALUControl1, BrUn1, ill1};
    assign obs2 = {PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, ResultSrc2,
                   ALUSrcA2, ALUSrcB2, ImmSrc2, ALUControl2, BrUn2, ill2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            OP_LOAD, OP_JALR, OP_I: return 3'b000;
            OP_STORE:               return 3'b001;
            OP_BRANCH:              return 3'b010;
            OP_JAL:                 return 3'b011;
            OP_LUI, OP_AUIPC:       return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input logic rtype);
        case (f3)
            3'b000:  return (rtype && f7) ? 4'b0001 : 4'b0000;
            3'b001:  return 4'b0111;
            3'b010:  return 4'b0101;
            3'b011:  return 4'b0110;
            3'b100:  return 4'b0100;
            3'b101:  return f7 ? 4'b1001 : 4'b1000;
            3'b110:  return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    // Expected output vector; ImmSrc always follows the current opcode.
    function automatic logic [19:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [3:0] alu, input logic brun, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm_of(op), alu, brun, ill};
    endfunction

    function automatic logic [19:0] fetch_v(input logic mr);
        return mk(mr, 1'b0, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 4'h0, 1'b0, 1'b0);
    endfunction

    function automatic logic [19:0] wb_v();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0);
    endfunction

    // One clock: compare outputs and counter mid-cycle, then advance.
    task automatic step(input string tag, input logic [19:0] exp);
        logic [31:0] mask;
        mask = sel ? 32'h0000_000F : 32'hFFFF_FFFF;
        @(negedge clk);
        check(tag, {12'h0, sel ? obs2 : obs1}, {12'h0, exp});
        check({tag, ".cnt"}, sel ? {28'h0, instret2} : instret1, exp_cnt & mask);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if (sel) rst2 = 1'b1; else rst1 = 1'b1;
        mem_ready = 1'($urandom);
        step("reset", fetch_v(mem_ready));
        exp_cnt = '0;
        if (sel) rst2 = 1'b0; else rst1 = 1'b0;
    endtask

    // Drives one instruction through the selected instance; trapped=1 if it trapped.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int unsigned fw, input int unsigned mw,
                             input logic eq, input logic lt, output bit trapped);
        bit legal, tk, trap_en, jalr_en;
        trap_en  = !sel;
        jalr_en  = !sel;
        trapped  = 1'b0;
        op = o; funct3 = f3; funct7b5 = f7; BrEq = eq; BrLT = lt;
        for (int unsigned i = 0; i <= fw; i++) begin
            mem_ready = (i == fw);
            step("fetch", fetch_v(mem_ready));
        end
        mem_ready = 1'($urandom);
        step("decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'h0, 0, 0));
        case (o)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
            OP_BRANCH: legal = (f3 != 3'b010) && (f3 != 3'b011);
            OP_JALR:   legal = jalr_en;
            default:   legal = 1'b0;
        endcase
        if (!legal) begin
            if (trap_en) begin
                for (int k = 0; k < 3; k++) begin
                    mem_ready = 1'($urandom);
                    step("trap", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 1));
                end
                trapped = 1'b1;
            end
            return;
        end
        mem_ready = 1'($urandom);
        case (o)
            OP_LOAD, OP_STORE: begin
                step("memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0, 0, 0));
                for (int unsigned i = 0; i <= mw; i++) begin
                    mem_ready = (i == mw);
                    if (o == OP_LOAD)
                        step("memread", mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0));
                    else
                        step("memwrite", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0));
                end
                if (o == OP_LOAD) begin
                    mem_ready = 1'($urandom);
                    step("memwb", mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'h0, 0, 0));
                end
            end
            OP_R, OP_I: begin
                step("execute", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == OP_R) ? 2'b00 : 2'b01,
                                   alu_of(f3, f7, o == OP_R), 0, 0));
                step("aluwb", wb_v());
            end
            OP_BRANCH: begin
                case (f3)
                    3'b000:         tk = eq;
                    3'b001:         tk = !eq;
                    3'b100, 3'b110: tk = lt;
                    default:        tk = !lt;
                endcase
                step("branch", mk(tk, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, f3[1], 0));
            end
            OP_JAL: begin
                step("jal", mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'h0, 0, 0));
                step("jal.wb", wb_v());
            end
            OP_JALR: begin
                step("jalr", mk(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 4'h0, 0, 0));
                step("jalrpc", mk(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 4'h0, 0, 0));
            end
            OP_LUI: step("lui", mk(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 4'h0, 0, 0));
            default: begin
                step("auipc", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'h0, 0, 0));
                step("auipc.wb", wb_v());
            end
        endcase
        exp_cnt = exp_cnt + 1;
    endtask

    task automatic run_random(input int unsigned n);
        logic [6:0] ops [9];
        logic [6:0] o;
        bit tr;
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        for (int unsigned i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) o = 7'($urandom);
            else o = ops[$urandom_range(0, 8)];
            run_instr(o, 3'($urandom), 1'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom), 1'($urandom), tr);
            if (tr) do_reset();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit tr;
        rst1 = 1'b1; rst2 = 1'b1; sel = 1'b0; exp_cnt = '0;
        op = OP_LOAD; funct3 = 3'b010; funct7b5 = 1'b0;
        BrEq = 1'b0; BrLT = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;

        // Default build
        do_reset();
        run_instr(OP_LOAD, 3'b010, 1'b0, 0, 3, 1'b0, 1'b0, tr);
        run_instr(OP_R, 3'b000, 1'b1, 0, 0, 1'b0, 1'b0, tr);
        run_instr(OP_BRANCH, 3'b110, 1'b0, 0, 0, 1'b0, 1'b1, tr);
        run_instr(OP_BRANCH, 3'b110, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        run_instr(OP_STORE, 3'b010, 1'b0, 1, 2, 1'b0, 1'b0, tr);
        run_instr(OP_JAL, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        run_instr(OP_JALR, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        run_instr(OP_LUI, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        run_instr(OP_AUIPC, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        run_instr(OP_I, 3'b101, 1'b1, 0, 0, 1'b0, 1'b0, tr);
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        if (tr) do_reset();
        run_instr(OP_BRANCH, 3'b011, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        if (tr) do_reset();

        // Reset while a store is waiting on memory
        op = OP_STORE; funct3 = 3'b010;
        mem_ready = 1'b1;
        step("abort.fetch", fetch_v(1'b1));
        step("abort.decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'h0, 0, 0));
        step("abort.memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0, 0, 0));
        mem_ready = 1'b0;
        step("abort.memwrite", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0));
        do_reset();
        mem_ready = 1'b0;
        step("abort.after", fetch_v(1'b0));

        run_random(150);
        mem_ready = 1'b0;
        step("tail1", fetch_v(1'b0));

        // No-trap, no-JALR, 4-bit counter build
        rst1 = 1'b1;
        sel = 1'b1;
        exp_cnt = '0;
        do_reset();
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        run_instr(OP_JALR, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        run_instr(OP_BRANCH, 3'b010, 1'b0, 0, 0, 1'b0, 1'b0, tr);
        for (int unsigned i = 0; i < 16; i++)
            run_instr(OP_I, 3'($urandom), 1'($urandom), 0, 0, 1'b0, 1'b0, tr);
        mem_ready = 1'b0;
        step("wrap", fetch_v(1'b0));
        run_random(100);
        mem_ready = 1'b0;
        step("tail2", fetch_v(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TRAP_ON_ILLEGAL, default 1: 1 = illegal instruction enters TRAP; 0 = illegal instruction is discarded and the FSM returns to FETCH.
REQ-002 Parameter SUPPORT_JALR, default 1: 1 = JALR decoded; 0 = opcode 1100111 is illegal.
REQ-003 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 One clock, clk; reset is synchronous and active-high, named reset.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- op  in  7  instruction opcode from the instruction register (IR).
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- BrEq  in  1  rs1 == rs2, from the datapath comparator.
- BrLT  in  1  rs1 < rs2, from the datapath comparator; signed or unsigned per BrUn.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  IR and OldPC enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- ALUSrcA  out  2  ALU operand A: 00 = PC, 01 = OldPC, 10 = A register (rs1, latched in DECODE).
- ALUSrcB  out  2  ALU operand B: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- ALUControl  out  4  ALU operation: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- BrUn  out  1  unsigned compare request to the datapath comparator.
- illegal_instr  out  1  high while the FSM is in TRAP.
- instret  out  CNT_W  retired-instruction count.

Function
REQ-006 ImmSrc is a pure function of op:
- load / JALR / I-type ALU -> I.
- store -> S.
- branch -> B.
- JAL -> J.
- LUI / AUIPC -> U.
- any other op -> 000.
REQ-007 Registered FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, JALRPC, LUI, AUIPC, TRAP; every output not listed for a state is 0 / 00.
REQ-008 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stays in FETCH until mem_ready=1, then goes to DECODE.
REQ-009 DECODE: ALUSrcA=01, ALUSrcB=01, add; next state by op:
- 0000011 / 0100011 -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI.
- 1100011 -> BRANCH, except funct3 010/011, which are illegal.
- 1101111 -> JAL.
- 1100111 -> JALR, when SUPPORT_JALR=1.
- 0110111 -> LUI.
- 0010111 -> AUIPC.
- otherwise illegal.
REQ-010 MEMADR: ALUSrcA=10, ALUSrcB=01, add; goes to MEMREAD (load) or MEMWRITE (store).
REQ-011 MEMREAD: AdrSrc=1; holds until mem_ready=1, then goes to MEMWB.
REQ-012 MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
REQ-013 MEMWRITE: AdrSrc=1; MemWrite held high until mem_ready=1, then FETCH.
REQ-014 EXECUTER: ALUSrcA=10, ALUSrcB=00, then ALUWB.
REQ-015 EXECUTEI: ALUSrcA=10, ALUSrcB=01, then ALUWB.
REQ-016 ALU decode, by funct3:
- 000: sub only if R-type and funct7b5=1, else add.
- 001: sll.
- 010: slt.
- 011: sltu.
- 100: xor.
- 101: sra if funct7b5=1, else srl.
- 110: or.
- 111: and.
REQ-017 ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
REQ-018 BRANCH: ResultSrc=00, BrUn=funct3[1]; PCWrite=taken, then FETCH.
- 000 taken = BrEq; 001 taken = ~BrEq.
- 100 and 110 taken = BrLT; 101 and 111 taken = ~BrLT.
REQ-019 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB, which writes OldPC+4 to rd.
REQ-020 JALR: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1, then JALRPC.
REQ-021 JALRPC: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1, then FETCH; rd==rs1 is correct because rs1 comes from the A register.
REQ-022 LUI: ResultSrc=11, RegWrite=1, then FETCH.
REQ-023 AUIPC: ALUSrcA=01, ALUSrcB=01, add, then ALUWB.
REQ-024 Illegal instruction: with TRAP_ON_ILLEGAL=1, DECODE goes to TRAP; TRAP asserts illegal_instr=1, all strobes 0, and is left only by reset. With TRAP_ON_ILLEGAL=0, DECODE goes to FETCH and instret is unchanged.
REQ-025 instret increments by 1, wrapping modulo 2^CNT_W, on the clock edge leaving any of:
- MEMWB, ALUWB, BRANCH, JALRPC, LUI.
- MEMWRITE, only with mem_ready=1.
REQ-026 instret never counts twice for one instruction; JAL and AUIPC count only in ALUWB.

Reset
REQ-027 reset=1 at a clk edge forces state=FETCH, instret=0 and illegal_instr=0, overriding any in-progress state, pending mem_ready wait, or TRAP.
REQ-028 During and immediately after reset, outputs take FETCH values: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=0000, ResultSrc=10, IRWrite=PCWrite=mem_ready; all other strobes 0.

Verification
REQ-029 Load, op=0000011, mem_ready held 0 for 3 cycles in MEMREAD -> MEMREAD for 4 cycles; MEMWB asserts RegWrite=1, ResultSrc=01; instret 0->1.
REQ-030 R-type sub, funct3=000, funct7b5=1 -> EXECUTER ALUControl=0001; ALUWB RegWrite=1; 4 cycles from FETCH to FETCH with mem_ready=1.
REQ-031 bltu, funct3=110, BrLT=1 then BrLT=0 -> BRANCH BrUn=1 and PCWrite=1 in the first run, PCWrite=0 in the second; instret +1 each.
REQ-032 op=1111111 -> TRAP with illegal_instr=1 when TRAP_ON_ILLEGAL=1, stuck until reset; FETCH with no instret change when TRAP_ON_ILLEGAL=0.
REQ-033 CNT_W=4, 16 ALU instructions -> instret wraps 15->0.
REQ-034 reset asserted while in MEMWRITE with MemWrite=1 -> next cycle state=FETCH, MemWrite=0, instret=0.
